// File: rtl/wb_pkg.sv
// Shared widths and the stored writeback entry layout for the WB stage register.
package wb_pkg;

    localparam int unsigned WB_DATA_W_DEF  = 16;
    localparam int unsigned WB_RADDR_W_DEF = 3;

    typedef struct packed {
        logic                      reg_write;
        logic [WB_RADDR_W_DEF-1:0] rd_addr;
        logic [WB_DATA_W_DEF-1:0]  wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_stage_reg_if.sv
// MEM->WB handshake, writeback, forwarding and occupancy signals of the WB stage register.
interface wb_stage_reg_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RADDR_W = 3
);

    logic               m_valid;
    logic               m_ready;
    logic               m_mem_to_reg;
    logic               m_reg_write;
    logic [RADDR_W-1:0] m_rd_addr;
    logic [DATA_W-1:0]  m_mem_rdata;
    logic [DATA_W-1:0]  m_alu_result;

    logic               w_valid;
    logic               w_ready;
    logic               w_reg_write;
    logic [RADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0]  w_wdata;

    logic               fwd_valid;
    logic [RADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0]  fwd_data;
    logic [1:0]         occ;

    // Environment side: MEM producer, register-file consumer, forwarding observer.
    modport master (
        output m_valid, m_mem_to_reg, m_reg_write, m_rd_addr, m_mem_rdata, m_alu_result, w_ready,
        input  m_ready, w_valid, w_reg_write, w_rd_addr, w_wdata, fwd_valid, fwd_addr, fwd_data, occ
    );

    // Stage side.
    modport slave (
        input  m_valid, m_mem_to_reg, m_reg_write, m_rd_addr, m_mem_rdata, m_alu_result, w_ready,
        output m_ready, w_valid, w_reg_write, w_rd_addr, w_wdata, fwd_valid, fwd_addr, fwd_data, occ
    );

endinterface

// File: rtl/wb_entry_slot.sv
// One enable-loaded writeback entry register with a valid flag; clear drops valid but keeps payload.
module wb_entry_slot #(
    parameter int unsigned W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         drop,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register with writeback-data select, r0 write suppression and forwarding tap.
// Define WB_STAGE_SKID_EN for a two-entry skid buffer with registered m_ready.
module wb_stage_reg
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W  = WB_DATA_W_DEF,
    parameter int unsigned RADDR_W = WB_RADDR_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    wb_stage_reg_if.slave  bus
);

    localparam int unsigned ENTRY_W = 1 + RADDR_W + DATA_W;

    logic               accept;
    logic               retire;
    logic [ENTRY_W-1:0] inEntry;
    logic [ENTRY_W-1:0] headD;
    logic [ENTRY_W-1:0] headQ;
    logic               headValid;
    logic               headLoad;
    logic               headDrop;
    logic               storedWrite;

    assign inEntry = {bus.m_reg_write, bus.m_rd_addr,
                      bus.m_mem_to_reg ? bus.m_mem_rdata : bus.m_alu_result};
    assign accept  = bus.m_valid && bus.m_ready;
    assign retire  = headValid && bus.w_ready;

`ifdef WB_STAGE_SKID_EN
    logic               skidValid;
    logic               skidLoad;
    logic [ENTRY_W-1:0] skidQ;

    // Skid is only ever occupied behind a valid head, so !skidValid is exactly occ<2.
    assign bus.m_ready = !skidValid;
    assign bus.occ     = skidValid ? 2'd2 : {1'b0, headValid};

    always_comb begin
        headD    = inEntry;
        headLoad = 1'b0;
        skidLoad = 1'b0;
        headDrop = retire;
        if (skidValid) begin
            headD    = skidQ;
            headLoad = retire;
        end else begin
            headLoad = accept && (!headValid || retire);
            skidLoad = accept && headValid && !retire;
        end
    end

    wb_entry_slot #(.W(ENTRY_W)) skidSlot (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .load  (skidLoad),
        .drop  (retire),
        .d     (inEntry),
        .valid (skidValid),
        .q     (skidQ)
    );
`else
    assign bus.m_ready = !headValid || bus.w_ready;
    assign bus.occ     = {1'b0, headValid};

    always_comb begin
        headD    = inEntry;
        headLoad = accept;
        headDrop = retire;
    end
`endif

    wb_entry_slot #(.W(ENTRY_W)) headSlot (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .load  (headLoad),
        .drop  (headDrop),
        .d     (headD),
        .valid (headValid),
        .q     (headQ)
    );

    assign {storedWrite, bus.w_rd_addr, bus.w_wdata} = headQ;
    assign bus.w_valid     = headValid;
    assign bus.w_reg_write = headValid && storedWrite && (bus.w_rd_addr != '0);
    assign bus.fwd_valid   = bus.w_reg_write;
    assign bus.fwd_addr    = bus.w_rd_addr;
    assign bus.fwd_data    = bus.w_wdata;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Randomized and directed bench for wb_stage_reg against a queue-based reference model.
module tb_wb_stage_reg;
    import wb_pkg::*;

`ifdef WB_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic flush;

    wb_stage_reg_if #(.DATA_W(16), .RADDR_W(3)) bus ();

    wb_stage_reg #(.DATA_W(16), .RADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    wb_entry_t modelQ[$];
    wb_entry_t lastHead = '0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic expReady();
        if (CAP == 2) return modelQ.size() < 2;
        return (modelQ.size() == 0) || bus.w_ready;
    endfunction

    task automatic checkOutputs();
        wb_entry_t h;
        logic      v;
        logic      wr;
        v  = modelQ.size() > 0;
        h  = v ? modelQ[0] : lastHead;
        wr = v && h.reg_write && (h.rd_addr != 3'd0);
        checkVal("m_ready", bus.m_ready, expReady());
        checkVal("w_valid", bus.w_valid, v);
        checkVal("occ", bus.occ, modelQ.size());
        checkVal("w_rd_addr", bus.w_rd_addr, h.rd_addr);
        checkVal("w_wdata", bus.w_wdata, h.wdata);
        checkVal("w_reg_write", bus.w_reg_write, wr);
        checkVal("fwd_valid", bus.fwd_valid, wr);
        checkVal("fwd_addr", bus.fwd_addr, h.rd_addr);
        checkVal("fwd_data", bus.fwd_data, h.wdata);
    endtask

    task automatic updateModel();
        wb_entry_t e;
        logic      acc;
        logic      ret;
        if (reset) begin
            modelQ.delete();
            lastHead = '0;
        end else if (flush) begin
            modelQ.delete();
        end else begin
            acc = bus.m_valid && expReady();
            ret = (modelQ.size() > 0) && bus.w_ready;
            e.reg_write = bus.m_reg_write;
            e.rd_addr   = bus.m_rd_addr;
            e.wdata     = bus.m_mem_to_reg ? bus.m_mem_rdata : bus.m_alu_result;
            if (ret) void'(modelQ.pop_front());
            if (acc) modelQ.push_back(e);
        end
        if (modelQ.size() > 0) lastHead = modelQ[0];
    endtask

    // Inputs are set at edge+1; outputs are sampled at edge+4, well before the next edge.
    task automatic cycle();
        #3;
        checkOutputs();
        updateModel();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic m2r, input logic rw, input logic [2:0] rd,
                         input logic [15:0] md, input logic [15:0] alu);
        bus.m_valid      = v;
        bus.m_mem_to_reg = m2r;
        bus.m_reg_write  = rw;
        bus.m_rd_addr    = rd;
        bus.m_mem_rdata  = md;
        bus.m_alu_result = alu;
    endtask

    task automatic doReset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.w_ready = 1'b1;
        offer(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        doReset();
        checkVal("rst_m_ready", bus.m_ready, 1'b1);
        checkVal("rst_occ", bus.occ, 2'd0);

        // ALU result path
        offer(1'b1, 1'b0, 1'b1, 3'd3, 16'h5555, 16'h1234);
        cycle();
        checkVal("alu_w_valid", bus.w_valid, 1'b1);
        checkVal("alu_wdata", bus.w_wdata, 16'h1234);
        checkVal("alu_reg_write", bus.w_reg_write, 1'b1);
        checkVal("alu_fwd_addr", bus.fwd_addr, 3'd3);

        // Memory data path
        offer(1'b1, 1'b1, 1'b1, 3'd5, 16'hBEEF, 16'h0001);
        cycle();
        checkVal("mem_wdata", bus.w_wdata, 16'hBEEF);

        // Register 0 is never written
        offer(1'b1, 1'b0, 1'b1, 3'd0, 16'h0, 16'h7777);
        cycle();
        checkVal("r0_w_valid", bus.w_valid, 1'b1);
        checkVal("r0_reg_write", bus.w_reg_write, 1'b0);
        checkVal("r0_fwd_valid", bus.fwd_valid, 1'b0);
        offer(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        cycle();

        // Back-pressure: A, B, C offered back to back, then drained
        bus.w_ready = 1'b0;
        offer(1'b1, 1'b0, 1'b1, 3'd1, 16'h0, 16'h0011);
        cycle();
        offer(1'b1, 1'b0, 1'b1, 3'd2, 16'h0, 16'h0022);
        cycle();
        offer(1'b1, 1'b0, 1'b1, 3'd4, 16'h0, 16'h0033);
`ifdef WB_STAGE_SKID_EN
        checkVal("bp_occ_full", bus.occ, 2'd2);
        checkVal("bp_m_ready_c", bus.m_ready, 1'b0);
        checkVal("bp_head_a", bus.w_wdata, 16'h0011);
`endif
        cycle();
        bus.w_ready = 1'b1;
        cycle();
`ifdef WB_STAGE_SKID_EN
        checkVal("bp_head_b", bus.w_wdata, 16'h0022);
`endif
        cycle();
`ifdef WB_STAGE_SKID_EN
        checkVal("bp_head_c", bus.w_wdata, 16'h0033);
`endif
        offer(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) cycle();

        // Flush while full with a simultaneous offer
        bus.w_ready = 1'b0;
        offer(1'b1, 1'b0, 1'b1, 3'd6, 16'h0, 16'h00A1);
        cycle();
        offer(1'b1, 1'b0, 1'b1, 3'd7, 16'h0, 16'h00A2);
        cycle();
        offer(1'b1, 1'b0, 1'b1, 3'd2, 16'h0, 16'h00A3);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        offer(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        checkVal("flush_occ", bus.occ, 2'd0);
        checkVal("flush_w_valid", bus.w_valid, 1'b0);
        cycle();
        checkVal("flush_not_kept", bus.w_valid, 1'b0);

        // Reset with one held entry and a concurrent offer
        offer(1'b1, 1'b0, 1'b1, 3'd5, 16'h0, 16'h0C0C);
        cycle();
        offer(1'b1, 1'b1, 1'b1, 3'd6, 16'hD0D0, 16'h0);
        doReset();
        offer(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        bus.w_ready = 1'b1;
        checkVal("rst2_occ", bus.occ, 2'd0);
        checkVal("rst2_w_valid", bus.w_valid, 1'b0);
        checkVal("rst2_reg_write", bus.w_reg_write, 1'b0);
        checkVal("rst2_fwd_valid", bus.fwd_valid, 1'b0);
        checkVal("rst2_rd_addr", bus.w_rd_addr, 3'd0);
        checkVal("rst2_wdata", bus.w_wdata, 16'h0);
        checkVal("rst2_m_ready", bus.m_ready, 1'b1);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            offer($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 3'($urandom),
                  16'($urandom), 16'($urandom));
            bus.w_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 29) == 0;
            reset = $urandom_range(0, 59) == 0;
            cycle();
        end
        flush = 1'b0;
        reset = 1'b0;
        offer(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage_reg.md
WB_STAGE_REG -- requirements
Module: wb_stage_reg

Interface
REQ-001 Parameter DATA_W, default 16, width of memory read data, ALU result and writeback data.
REQ-002 Parameter RADDR_W, default 3, width of destination register address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all held entries.
REQ-006 m_valid  input  1  MEM-side entry offered.
REQ-007 m_ready  output  1  stage accepts MEM-side entry this cycle.
REQ-008 m_mem_to_reg  input  1  entry writes back memory data (1) or ALU result (0).
REQ-009 m_reg_write  input  1  entry writes the register file.
REQ-010 m_rd_addr  input  RADDR_W  destination register.
REQ-011 m_mem_rdata  input  DATA_W  memory read data.
REQ-012 m_alu_result  input  DATA_W  ALU result.
REQ-013 w_valid  output  1  WB-side entry present.
REQ-014 w_ready  input  1  register file consumes WB entry this cycle.
REQ-015 w_reg_write  output  1  qualified write enable.
REQ-016 w_rd_addr  output  RADDR_W  destination register of head entry.
REQ-017 w_wdata  output  DATA_W  selected writeback data of head entry.
REQ-018 fwd_valid, fwd_addr, fwd_data  output  1/RADDR_W/DATA_W  forwarding tap of head entry.
REQ-019 occ  output  2  entries held (0..2).

Function
REQ-020 Accept when m_valid && m_ready; retire when w_valid && w_ready.
REQ-021 Write-data select at capture: mem_to_reg ? mem_rdata : alu_result; only selected DATA_W value and rd_addr/reg_write are stored.
REQ-022 w_reg_write = w_valid && stored reg_write && (w_rd_addr != 0); register 0 never written.
REQ-023 fwd_valid = w_reg_write; fwd_addr = w_rd_addr; fwd_data = w_wdata.
REQ-024 Latency: accepted entry appears on w_* the cycle after acceptance when stage was empty or head retires same cycle.
REQ-025 Order preserved FIFO; no entry duplicated or dropped except by flush/reset.
REQ-026 Simultaneous accept and retire: occ unchanged, new entry moves to head if old head retired.
REQ-027 flush: next edge occ=0, w_valid=0; an accept in the flush cycle is discarded; flush has priority over accept and retire.
REQ-028 w_* payload outputs hold last value when w_valid=0 (don't-care to consumers, but stable).
REQ-029 m_valid with m_ready=0: no state change; MEM side must hold payload.

Reset
REQ-030 reset (synchronous) priority over flush: next edge occ=0, w_valid=0, w_reg_write=0, fwd_valid=0, w_rd_addr=0, w_wdata=0, m_ready=1 after edge.
REQ-031 Reset mid-transfer discards all entries including one accepted in reset cycle.

Configuration
REQ-032 Macro WB_STAGE_SKID_EN defined: two-entry skid buffer (head + skid); m_ready is registered, = (occ<2), independent of w_ready same cycle; full throughput under back-pressure.
REQ-033 Macro undefined: single entry; m_ready = !w_valid || w_ready (combinational); occ never exceeds 1; all other requirements unchanged.

Structure
REQ-034 Shared package wb_pkg holds WB_DATA_W_DEF, WB_RADDR_W_DEF and a packed typedef wb_entry_t {reg_write, rd_addr, wdata}.
REQ-035 One sub-module wb_entry_slot (enable-loaded entry register with valid) instanced once or twice per configuration.

Verification
REQ-036 Reset, then m_valid=1, alu_result=0x1234, mem_to_reg=0, rd=3, reg_write=1, w_ready=1 -> next cycle w_valid=1, w_wdata=0x1234, w_reg_write=1, fwd_addr=3.
REQ-037 mem_to_reg=1, mem_rdata=0xBEEF, alu_result=0x0001 -> w_wdata=0xBEEF.
REQ-038 rd=0, reg_write=1 -> w_valid=1, w_reg_write=0, fwd_valid=0.
REQ-039 SKID_EN: w_ready=0, offer entries A=0x0011, B=0x0022, C=0x0033 back-to-back -> A,B accepted, occ=2, m_ready=0 on C; release w_ready -> outputs A then B then C, no loss.
REQ-040 occ=2, assert flush together with m_valid=1 -> next cycle occ=0, w_valid=0, offered entry not retained.
REQ-041 reset asserted with occ=1 and m_valid=1 -> next cycle all outputs at reset values, occ=0.
